rr_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 31 +++
 rtl/rr_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// State encoding, default sizing and one-hot encode.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_N_DEF = 4;
  localparam int unsigned ARB_MAX_HOLD_DEF = 8;
  localparam int unsigned ARB_ID_W = $clog2(ARB_N_DEF);
  localparam int unsigned ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot(
    input int unsigned idx
  );
    logic [ONEHOT_W-1:0] v;
    v = '0;
    v[idx[4:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit
// at or after start, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  always_comb begin
    int j;
    logic [N-1:0] sh;
    found = 1'b0;
    idx = '0;
    j = 0;
    sh = '0;
    for (int k = 0; k < int'(N); k++) begin
      j = int'(start) + k;
      if (j >= int'(N)) j = j - int'(N);
      sh = req >> j;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant,
// owner hold until release, and optional hold timeout.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N = ARB_N_DEF,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic           any_req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           timeout
);

  localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? '1 : HCW'(MAX_HOLD - 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           tmo_q, tmo_d;

  logic [IDW-1:0] start;
  logic           found;
  logic [IDW-1:0] win;
  logic           owner_req;
  logic           tmo_hit;
  logic           release_c;

  assign any_req = |req;

  // Search always starts just past the last owner
  assign start = (ptr_q == IDW'(N - 1)) ? '0 : ptr_q + IDW'(1);

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  assign owner_req = |(req & grant_q);
  assign tmo_hit = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);
  assign release_c = done || !owner_req || tmo_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    id_d = id_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    tmo_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = N'(onehot(32'(win)));
          valid_d = 1'b1;
          id_d = win;
          ptr_d = win;
          hold_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_c) begin
          tmo_d = tmo_hit && !done && owner_req;
          hold_d = '0;
          if (found) begin
            grant_d = N'(onehot(32'(win)));
            valid_d = 1'b1;
            id_d = win;
            ptr_d = win;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            id_d = '0;
            state_d = IDLE;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q <= '0;
      ptr_q <= IDW'(N - 1);
      hold_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      tmo_q <= tmo_d;
    end
  end

  assign grant = grant_q;
  assign grant_valid = valid_q;
  assign grant_id = id_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed vector bench for rr_arbiter (N=4, MAX_HOLD=8).
// Table rows plus hand sequences for timeout and reset.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       any_req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .any_req     (any_req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       any;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic       tmo;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(
    input string name,
    input logic [3:0] g,
    input logic v,
    input logic [1:0] id,
    input logic t
  );
    checks++;
    if (grant !== g || grant_valid !== v ||
        grant_id !== id || timeout !== t) begin
      errors++;
      $display("FAIL %s: got grant=%b valid=%b id=%0d tmo=%b want grant=%b valid=%b id=%0d tmo=%b",
               name, grant, grant_valid, grant_id, timeout,
               g, v, id, t);
    end
  endtask

  task automatic chk_any(input string name, input logic a);
    checks++;
    if (any_req !== a) begin
      errors++;
      $display("FAIL %s: got any_req=%b want %b", name, any_req, a);
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{4'b0101, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[10] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[11] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[12] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[13] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[16] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};

    rst = 1'b1;
    req = '0;
    done = 1'b0;
    step();
    step();
    chk_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      req = vecs[i].req;
      done = vecs[i].done;
      #1;
      chk_any($sformatf("vec%0d_any", i), vecs[i].any);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].vld,
              vecs[i].id, vecs[i].tmo);
    end

    // Timeout: ptr=2, so 0011 wraps to requester 0
    done = 1'b0;
    req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("tmo_hold%0d", i), 4'b0001, 1'b1, 2'd0, 1'b0);
    end
    step();
    chk_out("tmo_switch", 4'b0010, 1'b1, 2'd1, 1'b1);
    step();
    chk_out("tmo_after", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("tmo_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

    // done coinciding with timeout on the 8th held cycle
    req = 4'b1000;
    step();
    chk_out("dt_grant", 4'b1000, 1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 7; i++) step();
    done = 1'b1;
    step();
    chk_out("dt_regrant", 4'b1000, 1'b1, 2'd3, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out($sformatf("dt_hold%0d", i), 4'b1000, 1'b1, 2'd3, 1'b0);
    end
    step();
    chk_out("dt_tmo", 4'b1000, 1'b1, 2'd3, 1'b1);
    req = 4'b0000;
    step();
    chk_out("dt_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Reset mid-grant; ptr=3, 0010 wins
    req = 4'b0010;
    step();
    chk_out("rst_pre", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0011;
    rst = 1'b1;
    #1;
    chk_any("rst_any", 1'b1);
    step();
    chk_out("rst_mid", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    chk_out("rst_regrant", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Owner 0 now; after reset, ptr back to 3 favours 0 over 3
    rst = 1'b1;
    step();
    chk_out("rst2", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1001;
    step();
    chk_out("rst2_ptr", 4'b0001, 1'b1, 2'd0, 1'b0);
    req = 4'b1001;
    done = 1'b1;
    step();
    chk_out("wrap_next", 4'b1000, 1'b1, 2'd3, 1'b0);
    req = 4'b1000;
    step();
    chk_out("sole_regrant", 4'b1000, 1'b1, 2'd3, 1'b0);
    done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
